// File: rtl/thresholding_top.sv
// thresholding_top: binary thresholding of an 8-bit grayscale frame.
//
// A host loads packed pixels into the pixel memory MemP (NWORDS x 32) and
// pulses Go_t. The core then reads each word and writes one byte per pixel
// into the binary memory MemB (4*NWORDS x 8). Each byte is 8'hFF when
// pixel >= THRESH and 8'h00 otherwise. The host reads the results back
// through its own MemB port. The core has private ports on both memories,
// so host accesses never stall it.
//
// Build option: define THRESH_INVERT_EN to swap the result polarity
// (8'h00 when pixel >= THRESH, 8'hFF otherwise).
//
// Ports:
//   Clk          single rising-edge clock
//   Rst_Core     async active-low reset of the core FSM, Done_t and MB_do8
//   Rst_P        async active-low reset of the host MemP read register
//   Rst_B        async active-low reset of the host MemB read register
//   Go_t         start strobe, sampled in IDLE and DONE
//   Done_t       level-high completion flag
//   MP_di31      host MemP write data
//   MP_Addr15    host MemP word address
//   MP_enb       host MemP port enable
//   MP_web       host MemP write enable (with MP_enb)
//   MP_do31      host MemP read data (1-cycle latency)
//   MP_di8       debug: pixel byte the core is processing
//   MB_Addr17_2  host MemB read address
//   MB_ena       host MemB port enable
//   MB_wea       host MemB write enable; no write data, access ignored
//   MB_do8_2     host MemB read data (1-cycle latency)
//   MB_di8_2     debug: byte the core is writing to MemB
//   MB_do8       debug: registered copy of the last byte the core wrote
module thresholding_top #(
  parameter int unsigned THRESH  = 128,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 17,
  parameter int unsigned NWORDS  = 19200
) (
  input  logic               Clk,
  input  logic               Rst_Core,
  input  logic               Rst_P,
  input  logic               Rst_B,
  input  logic               Go_t,
  output logic               Done_t,
  input  logic [31:0]        MP_di31,
  input  logic [14:0]        MP_Addr15,
  input  logic               MP_enb,
  input  logic               MP_web,
  output logic [31:0]        MP_do31,
  output logic [D_WIDTH-1:0] MP_di8,
  input  logic [A_WIDTH-1:0] MB_Addr17_2,
  input  logic               MB_ena,
  input  logic               MB_wea,
  output logic [D_WIDTH-1:0] MB_do8_2,
  output logic [D_WIDTH-1:0] MB_di8_2,
  output logic [D_WIDTH-1:0] MB_do8
);

  localparam int unsigned PW = $clog2(NWORDS);
  localparam int unsigned BW = PW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  logic [31:0]        memp [NWORDS];
  logic [D_WIDTH-1:0] memb [4*NWORDS];

  state_t             state_q, state_d;
  logic [PW-1:0]      word_q, word_d;
  logic [1:0]         byte_q, byte_d;
  logic               done_q, done_d;
  logic [D_WIDTH-1:0] mbo_q, mbo_d;
  logic [31:0]        cp_q;
  logic [31:0]        mp_do_q;
  logic [D_WIDTH-1:0] mb_do_q;

  logic               core_rd, core_we;
  logic [7:0]         pix;
  logic [D_WIDTH-1:0] bin;
  logic               host_p_hit, host_b_hit;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    done_d  = done_q;
    core_rd = 1'b0;
    core_we = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Go_t) begin
          state_d = S_RD;
          word_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_RD: begin
        core_rd = 1'b1;
        byte_d  = '0;
        state_d = S_WR;
      end
      S_WR: begin
        core_we = 1'b1;
        byte_d  = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          if (word_q == PW'(NWORDS - 1)) begin
            state_d = S_DONE;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (Go_t) begin
          state_d = S_RD;
          word_d  = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel 4k sits in the top byte of word k.
  always_comb begin
    pix = '0;
    unique case (byte_q)
      2'd0: pix = cp_q[31:24];
      2'd1: pix = cp_q[23:16];
      2'd2: pix = cp_q[15:8];
      2'd3: pix = cp_q[7:0];
      default: pix = '0;
    endcase
  end

`ifdef THRESH_INVERT_EN
  assign bin = (pix >= 8'(THRESH)) ? '0 : '1;
`else
  assign bin = (pix >= 8'(THRESH)) ? '1 : '0;
`endif

  assign mbo_d    = core_we ? bin : mbo_q;
  assign MP_di8   = core_we ? D_WIDTH'(pix) : '0;
  assign MB_di8_2 = core_we ? bin : '0;

  always_ff @(posedge Clk or negedge Rst_Core) begin
    if (!Rst_Core) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      mbo_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      mbo_q   <= mbo_d;
    end
  end

  // Core ports: read MemP in RD, write MemB once per WR cycle.
  always_ff @(posedge Clk) begin
    if (core_rd) cp_q <= memp[word_q];
  end

  always_ff @(posedge Clk) begin
    if (core_we) memb[{word_q, byte_q}] <= bin;
  end

  // Host ports: out-of-range addresses are ignored.
  assign host_p_hit = MP_enb && (32'(MP_Addr15) < NWORDS);
  assign host_b_hit = MB_ena && !MB_wea && (32'(MB_Addr17_2) < 4 * NWORDS);

  always_ff @(posedge Clk) begin
    if (host_p_hit && MP_web) memp[MP_Addr15[PW-1:0]] <= MP_di31;
  end

  always_ff @(posedge Clk or negedge Rst_P) begin
    if (!Rst_P) begin
      mp_do_q <= '0;
    end else if (host_p_hit && !MP_web) begin
      mp_do_q <= memp[MP_Addr15[PW-1:0]];
    end
  end

  always_ff @(posedge Clk or negedge Rst_B) begin
    if (!Rst_B) begin
      mb_do_q <= '0;
    end else if (host_b_hit) begin
      mb_do_q <= memb[MB_Addr17_2[BW-1:0]];
    end
  end

  assign Done_t   = done_q;
  assign MP_do31  = mp_do_q;
  assign MB_do8_2 = mb_do_q;
  assign MB_do8   = mbo_q;

endmodule

// File: tb/tb_thresholding_top.sv
// Scoreboard bench for thresholding_top, run on a reduced frame size.
// Host reads push the expected word/byte into a queue; a monitor pops and
// compares one cycle after each read is sampled. Expected results come from
// a pixel-array model with the threshold rule applied directly.
module tb_thresholding_top;

  localparam int N  = 64;
  localparam int NP = 4 * N;

  logic        Clk = 1'b0;
  logic        Rst_Core, Rst_P, Rst_B, Go_t, Done_t;
  logic [31:0] MP_di31, MP_do31;
  logic [14:0] MP_Addr15;
  logic        MP_enb, MP_web;
  logic [7:0]  MP_di8;
  logic [16:0] MB_Addr17_2;
  logic        MB_ena, MB_wea;
  logic [7:0]  MB_do8_2, MB_di8_2, MB_do8;

  always #5 Clk = ~Clk;

  thresholding_top #(
    .THRESH (128),
    .D_WIDTH(8),
    .A_WIDTH(17),
    .NWORDS (N)
  ) dut (
    .Clk        (Clk),
    .Rst_Core   (Rst_Core),
    .Rst_P      (Rst_P),
    .Rst_B      (Rst_B),
    .Go_t       (Go_t),
    .Done_t     (Done_t),
    .MP_di31    (MP_di31),
    .MP_Addr15  (MP_Addr15),
    .MP_enb     (MP_enb),
    .MP_web     (MP_web),
    .MP_do31    (MP_do31),
    .MP_di8     (MP_di8),
    .MB_Addr17_2(MB_Addr17_2),
    .MB_ena     (MB_ena),
    .MB_wea     (MB_wea),
    .MB_do8_2   (MB_do8_2),
    .MB_di8_2   (MB_di8_2),
    .MB_do8     (MB_do8)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  pix [NP];
  logic [7:0]  memb_model [NP];
  logic [7:0]  qb [$];
  logic [31:0] qp [$];
  logic        rdb_pend = 1'b0;
  logic        rdp_pend = 1'b0;

  function automatic logic [7:0] ref_bin(input logic [7:0] p);
`ifdef THRESH_INVERT_EN
    return (p >= 8'd128) ? 8'h00 : 8'hFF;
`else
    return (p >= 8'd128) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read sampled on a rising edge is checked at the next falling edge.
  always @(posedge Clk) begin
    rdb_pend <= MB_ena && !MB_wea && Rst_B;
    rdp_pend <= MP_enb && !MP_web && Rst_P;
  end

  always @(negedge Clk) begin
    if (rdb_pend) begin
      if (qb.size() == 0) check("memb_unexpected_read", 32'd1, 32'd0);
      else                check("memb_read", {24'd0, MB_do8_2}, {24'd0, qb.pop_front()});
    end
    if (rdp_pend) begin
      if (qp.size() == 0) check("memp_unexpected_read", 32'd1, 32'd0);
      else                check("memp_read", MP_do31, qp.pop_front());
    end
  end

  // All host tasks start and end just after a falling edge.
  task automatic load_word(input int a, input logic [31:0] d);
    pix[4*a]   = d[31:24];
    pix[4*a+1] = d[23:16];
    pix[4*a+2] = d[15:8];
    pix[4*a+3] = d[7:0];
    MP_enb = 1'b1; MP_web = 1'b1; MP_Addr15 = 15'(a); MP_di31 = d;
    @(negedge Clk);
    MP_enb = 1'b0; MP_web = 1'b0;
  endtask

  task automatic read_p(input int a);
    MP_enb = 1'b1; MP_web = 1'b0; MP_Addr15 = 15'(a);
    qp.push_back({pix[4*a], pix[4*a+1], pix[4*a+2], pix[4*a+3]});
    @(negedge Clk);
    MP_enb = 1'b0;
  endtask

  task automatic read_b(input int a);
    MB_ena = 1'b1; MB_wea = 1'b0; MB_Addr17_2 = 17'(a);
    qb.push_back(memb_model[a]);
    @(negedge Clk);
    MB_ena = 1'b0;
  endtask

  task automatic read_all_b();
    for (int a = 0; a < NP; a++) read_b(a);
    @(negedge Clk);
  endtask

  function automatic logic [7:0] rnd_pix();
    case ($urandom_range(0, 7))
      0: return 8'd127;
      1: return 8'd128;
      2: return 8'd0;
      3: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic load_random_frame(input int first);
    for (int w = first; w < N; w++)
      load_word(w, {rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix()});
  endtask

  // Pulse Go_t, check Done_t drops and rises exactly 5*N+1 edges later.
  task automatic run_check(input string tag);
    int edges;
    edges = -1;
    Go_t = 1'b1;
    @(negedge Clk);
    Go_t = 1'b0;
    check({tag, "_done_low_after_go"}, {31'd0, Done_t}, 32'd0);
    for (int k = 1; k <= 5 * N + 40; k++) begin
      @(negedge Clk);
      if (Done_t) begin
        edges = k;
        break;
      end
    end
    check({tag, "_done_latency"}, 32'(edges), 32'(5 * N + 1));
    repeat (3) @(negedge Clk);
    check({tag, "_done_holds"}, {31'd0, Done_t}, 32'd1);
    for (int i = 0; i < NP; i++) memb_model[i] = ref_bin(pix[i]);
  endtask

  initial begin
    int bad;
    Rst_Core = 1'b0; Rst_P = 1'b0; Rst_B = 1'b0; Go_t = 1'b0;
    MP_di31 = '0; MP_Addr15 = '0; MP_enb = 1'b0; MP_web = 1'b0;
    MB_Addr17_2 = '0; MB_ena = 1'b0; MB_wea = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_Core = 1'b1; Rst_P = 1'b1; Rst_B = 1'b1;
    @(negedge Clk);
    check("rst_done",     {31'd0, Done_t}, 32'd0);
    check("rst_mp_do31",  MP_do31, 32'd0);
    check("rst_mp_di8",   {24'd0, MP_di8}, 32'd0);
    check("rst_mb_do8_2", {24'd0, MB_do8_2}, 32'd0);
    check("rst_mb_di8_2", {24'd0, MB_di8_2}, 32'd0);
    check("rst_mb_do8",   {24'd0, MB_do8}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done_t !== 1'b0) bad++;
    end
    check("idle_done_stays_low", 32'(bad), 32'd0);

    // Directed boundary word at address 0, random remainder.
`ifdef THRESH_INVERT_EN
    load_word(0, 32'h807F00FF);
`else
    load_word(0, 32'h007F80FF);
`endif
    load_random_frame(1);
    for (int a = 0; a < 4; a++) read_p(a);
    read_p(N - 1);
    run_check("first");
    for (int a = 0; a < 4; a++) read_b(a);
    // Write-enabled MemB access is ignored; output holds.
    MB_ena = 1'b1; MB_wea = 1'b1; MB_Addr17_2 = 17'd0;
    repeat (2) @(negedge Clk);
    MB_ena = 1'b0; MB_wea = 1'b0;
    check("memb_wea_ignored", {24'd0, MB_do8_2}, {24'd0, memb_model[3]});

    // Full random frame.
    load_random_frame(0);
    run_check("random");
    read_all_b();

    // Core reset mid-run, host changes the frame, then restart.
    load_random_frame(0);
    Go_t = 1'b1;
    @(negedge Clk);
    Go_t = 1'b0;
    repeat (5 * 10 + 3) @(negedge Clk);
    Rst_Core = 1'b0;
    #1;
    check("midrst_done",   {31'd0, Done_t}, 32'd0);
    check("midrst_mb_do8", {24'd0, MB_do8}, 32'd0);
    @(negedge Clk);
    Rst_Core = 1'b1;
    for (int w = 0; w < 16; w++) load_word(w, {rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix()});
    run_check("after_rst");
    read_all_b();

    // Restart straight from DONE with new data.
    load_random_frame(0);
    run_check("restart");
    read_all_b();

    // Rst_B clears the host MemB read register.
    Rst_B = 1'b0;
    #1;
    check("rstb_mb_do8_2", {24'd0, MB_do8_2}, 32'd0);
    @(negedge Clk);
    Rst_B = 1'b1;

    repeat (3) @(negedge Clk);
    check("queue_drain", 32'(qb.size() + qp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
